multicycle_control: RTL

- Multi-cycle control FSM for the RV32I subset: R-type ALU ops, ADDI, LW, SW, BEQ.
- Sequences one shared ALU and one unified instruction/data memory over several cycles per instruction.
- Sits beside the datapath registers (PC, oldPC, IR, A/B, ALUOut, MDR).
- Waits on a memory-ready handshake and counts retired instructions.

---
 rtl/riscv_ctrl_pkg.sv | 35 +++
 rtl/mc_output_decode.sv | 63 ++++++
 rtl/multicycle_control.sv | 82 ++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM states and control-field encodings for the multi-cycle RV32I controller
package riscv_ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, TRAP
  } state_t;
  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_FOUR  = 2'b01;
  localparam logic [1:0] B_IMM   = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_RF  = 2'b10;
  localparam logic [1:0] ALU_IF  = 2'b11;
  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       illegal_op;
  } ctrl_t;
endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode: Moore control decode; only pc_we/ir_we look at alu_zero/mem_ready
module mc_output_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_alu_zero,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_a = A_PC;
        o_ctrl.alu_src_b = B_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.ir_we     = i_mem_ready;
        o_ctrl.pc_we     = i_mem_ready;
      end
      DECODE: begin
        o_ctrl.alu_src_a = A_OLDPC;
        o_ctrl.alu_src_b = B_IMM;
      end
      EXEC_R: begin
        o_ctrl.alu_src_a = A_RS1;
        o_ctrl.alu_src_b = B_RS2;
        o_ctrl.alu_op    = ALU_RF;
      end
      EXEC_I: begin
        o_ctrl.alu_src_a = A_RS1;
        o_ctrl.alu_src_b = B_IMM;
        o_ctrl.alu_op    = ALU_IF;
      end
      ALU_WB: o_ctrl.reg_write = 1'b1;
      MEM_ADDR: begin
        o_ctrl.alu_src_a = A_RS1;
        o_ctrl.alu_src_b = B_IMM;
      end
      MEM_RD: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.mem_read = 1'b1;
      end
      MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      BRANCH: begin
        o_ctrl.alu_src_a = A_RS1;
        o_ctrl.alu_src_b = B_RS2;
        o_ctrl.alu_op    = ALU_SUB;
        o_ctrl.pc_source = 1'b1;
        o_ctrl.pc_we     = i_alu_zero;
      end
      TRAP: o_ctrl.illegal_op = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: state register, next-state logic and retired-instruction counter
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 pc_we,
  output logic                 ir_we,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 pc_source,
  output logic                 illegal_op,
  output logic [3:0]           state_o,
  output logic [INSTRET_W-1:0] instret
);
  state_t                r_state;
  state_t                w_next;
  ctrl_t                 w_ctrl;
  ctrl_t                 w_out;
  logic                  w_retire;
  logic [INSTRET_W-1:0]  r_instret;
  mc_output_decode u_dec (
    .i_state    (r_state),
    .i_alu_zero (alu_zero),
    .i_mem_ready(mem_ready),
    .o_ctrl     (w_ctrl)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + 1'b1;
    end
  end
  assign w_retire = (r_state == ALU_WB) || (r_state == MEM_WB) || (r_state == BRANCH) ||
                    ((r_state == MEM_WR) && mem_ready);
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = mem_ready ? DECODE : FETCH;
      DECODE:   w_next = (opcode == OP_R) ? EXEC_R :
                         (opcode == OP_I) ? EXEC_I :
                         (opcode == OP_LOAD || opcode == OP_STORE) ? MEM_ADDR :
                         (opcode == OP_BRANCH) ? BRANCH : TRAP;
      EXEC_R:   w_next = ALU_WB;
      EXEC_I:   w_next = ALU_WB;
      MEM_ADDR: w_next = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:   w_next = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   w_next = mem_ready ? FETCH : MEM_WR;
      default:  w_next = FETCH;
    endcase
  end
  // reset drops every request in the same cycle so memory sees an abort
  assign w_out      = reset ? '0 : w_ctrl;
  assign pc_we      = w_out.pc_we;
  assign ir_we      = w_out.ir_we;
  assign iord       = w_out.iord;
  assign mem_read   = w_out.mem_read;
  assign mem_write  = w_out.mem_write;
  assign reg_write  = w_out.reg_write;
  assign mem_to_reg = w_out.mem_to_reg;
  assign alu_src_a  = w_out.alu_src_a;
  assign alu_src_b  = w_out.alu_src_b;
  assign alu_op     = w_out.alu_op;
  assign pc_source  = w_out.pc_source;
  assign illegal_op = w_out.illegal_op;
  assign state_o    = r_state;
  assign instret    = reset ? '0 : r_instret;
endmodule
